// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//
// Shares one UART transmit byte channel between two packet-oriented
// requesters (0 = CPU store path, 1 = message engine). A granted requester
// keeps the channel until it sends a byte flagged Last or until MAX_BURST
// bytes have gone through, so packets from different sources never
// interleave. Ties in IDLE are broken round-robin against the most recent
// grant holder. A one-entry registered stage drives the UART, so requester
// data never reaches the UART pins combinationally.
//
// Ports:
//   Clock            system clock, all state changes on posedge
//   Reset            synchronous, active-high reset
//   Req0Data/Valid/Last, Req0Ready   requester 0 byte handshake
//   Req1Data/Valid/Last, Req1Ready   requester 1 byte handshake
//   UartDataIn/UartDataInValid       byte presented to the UART
//   UartDataInReady                  UART accepts the presented byte
//   Busy             high while a requester holds the lock
//   Owner            lock holder while locked, else most recent grant holder
//
// Parameter:
//   MAX_BURST        bytes per grant before a forced release (2..255)

module uart_tx_arbiter #(
  parameter int unsigned MAX_BURST = 16
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] Req0Data,
  input  logic       Req0Valid,
  input  logic       Req0Last,
  output logic       Req0Ready,
  input  logic [7:0] Req1Data,
  input  logic       Req1Valid,
  input  logic       Req1Last,
  output logic       Req1Ready,
  output logic [7:0] UartDataIn,
  output logic       UartDataInValid,
  input  logic       UartDataInReady,
  output logic       Busy,
  output logic       Owner
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t     state_reg;
  logic       owner_reg;
  logic       last_owner_reg;
  logic [7:0] cnt_reg;
  logic [7:0] out_data_reg;
  logic       out_valid_reg;
  logic       busy_reg;
  logic       owner_out_reg;

  // Requester inputs gathered into arrays so the selection logic is
  // written once for both sides.
  logic [7:0] req_data [2];
  logic [1:0] req_valid;
  logic [1:0] req_last;
  logic [1:0] req_ready;

  assign req_data[0]  = Req0Data;
  assign req_data[1]  = Req1Data;
  assign req_valid    = {Req1Valid, Req0Valid};
  assign req_last     = {Req1Last, Req0Last};
  assign Req0Ready    = req_ready[0];
  assign Req1Ready    = req_ready[1];

  logic       stage_free;
  logic       candidate;
  logic       sel;
  logic       accept;
  logic [7:0] sel_data;
  logic       sel_last;
  logic [8:0] cnt_inc;
  logic       burst_done;

  // The stage can take a new byte when empty, or when the byte it holds
  // leaves for the UART in this same cycle.
  assign stage_free = !out_valid_reg || UartDataInReady;

  // IDLE candidate: the single valid requester, or on a tie the one that
  // did not hold the most recent grant. With nobody valid the value is
  // irrelevant because no transfer can happen.
  always_comb begin
    candidate = req_valid[1];
    if (req_valid == 2'b11) begin
      candidate = !last_owner_reg;
    end
  end

  // While locked only the owner may be served.
  assign sel = (state_reg == LOCKED) ? owner_reg : candidate;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ready
      assign req_ready[gi] = !Reset && stage_free && (sel == 1'(gi));
    end
  endgenerate

  assign sel_data   = req_data[sel];
  assign sel_last   = req_last[sel];
  assign accept     = req_valid[sel] && req_ready[sel];

  // Nine bits so the comparison stays exact for MAX_BURST up to 255.
  assign cnt_inc    = {1'b0, cnt_reg} + 9'd1;
  assign burst_done = (cnt_inc == 9'(MAX_BURST));

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_reg      <= IDLE;
      owner_reg      <= 1'b1;
      last_owner_reg <= 1'b1;
      cnt_reg        <= 8'd0;
      out_data_reg   <= 8'h00;
      out_valid_reg  <= 1'b0;
      busy_reg       <= 1'b0;
      owner_out_reg  <= 1'b1;
    end else begin
      // Output stage: a newly accepted byte replaces whatever was held
      // (the held byte is leaving this cycle whenever accept is possible).
      if (accept) begin
        out_data_reg  <= sel_data;
        out_valid_reg <= 1'b1;
      end else if (UartDataInReady) begin
        out_valid_reg <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          if (accept) begin
            if (sel_last || (MAX_BURST == 1)) begin
              // Single-byte packet: grant starts and ends in one cycle.
              last_owner_reg <= sel;
              owner_out_reg  <= sel;
            end else begin
              state_reg     <= LOCKED;
              owner_reg     <= sel;
              cnt_reg       <= 8'd1;
              busy_reg      <= 1'b1;
              owner_out_reg <= sel;
            end
          end
        end

        LOCKED: begin
          // Owner dropping Valid just stalls here; the lock is kept.
          if (accept) begin
            if (sel_last || burst_done) begin
              state_reg      <= IDLE;
              last_owner_reg <= owner_reg;
              cnt_reg        <= 8'd0;
              busy_reg       <= 1'b0;
              owner_out_reg  <= owner_reg;
            end else begin
              cnt_reg <= cnt_inc[7:0];
            end
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign UartDataIn      = out_data_reg;
  assign UartDataInValid = out_valid_reg;
  assign Busy            = busy_reg;
  assign Owner           = owner_out_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter (instantiated with MAX_BURST = 4).
// Requester drivers feed bytes from per-requester queues; a reference model
// evaluated every cycle pushes accepted bytes into a scoreboard queue that
// is drained as the UART consumes output bytes.

module tb_uart_tx_arbiter;

  localparam int MAXB = 4;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] req_data  [2] = '{8'h00, 8'h00};
  logic       req_valid [2] = '{1'b0, 1'b0};
  logic       req_last  [2] = '{1'b0, 1'b0};
  logic       Req0Ready;
  logic       Req1Ready;
  logic [7:0] UartDataIn;
  logic       UartDataInValid;
  logic       uart_ready = 1'b1;
  logic       Busy;
  logic       Owner;

  always #5 Clock = ~Clock;

  uart_tx_arbiter #(.MAX_BURST(MAXB)) dut (
    .Clock           (Clock),
    .Reset           (Reset),
    .Req0Data        (req_data[0]),
    .Req0Valid       (req_valid[0]),
    .Req0Last        (req_last[0]),
    .Req0Ready       (Req0Ready),
    .Req1Data        (req_data[1]),
    .Req1Valid       (req_valid[1]),
    .Req1Last        (req_last[1]),
    .Req1Ready       (Req1Ready),
    .UartDataIn      (UartDataIn),
    .UartDataInValid (UartDataInValid),
    .UartDataInReady (uart_ready),
    .Busy            (Busy),
    .Owner           (Owner)
  );

  typedef struct {
    logic [7:0] data;
    logic       last;
    int         gap;   // idle cycles before this byte is offered
  } item_t;

  item_t q0[$];
  item_t q1[$];
  logic  acc [2] = '{1'b0, 1'b0};

  int n_vec = 0;
  int n_err = 0;
  int uart_mode = 0;   // 0 ready high, 1 random, 2 stalled

  // Reference model: lock holder (-1 = none), previous grant holder,
  // bytes in current grant, output stage occupancy and contents.
  int         m_holder = -1;
  int         m_prev   = 1;
  int         m_cnt    = 0;
  bit         m_full   = 1'b0;
  logic [7:0] m_data   = 8'h00;
  logic [7:0] exp_q[$];
  logic [7:0] out_log[$];
  logic [7:0] want[$];
  int         busy_cycles = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor / model: evaluated at negedge, when all inputs for the next
  // posedge are settled.
  int         winner;
  int         allowed;
  int         xfer;
  bit         sf;
  logic [1:0] rdy;
  logic [7:0] exp_b;

  always @(negedge Clock) begin
    rdy    = {Req1Ready, Req0Ready};
    acc[0] = req_valid[0] && Req0Ready;
    acc[1] = req_valid[1] && Req1Ready;
    if (Reset) begin
      chk("reset_ready0", int'(Req0Ready), 0);
      chk("reset_ready1", int'(Req1Ready), 0);
      m_holder = -1;
      m_prev   = 1;
      m_cnt    = 0;
      m_full   = 1'b0;
      m_data   = 8'h00;
      exp_q.delete();
    end else begin
      chk("out_valid", int'(UartDataInValid), int'(m_full));
      chk("out_data", int'(UartDataIn), int'(m_data));
      chk("busy", int'(Busy), int'(m_holder >= 0));
      chk("owner", int'(Owner), (m_holder >= 0) ? m_holder : m_prev);
      if (Busy) busy_cycles++;

      sf = !m_full || uart_ready;
      if (req_valid[0] && req_valid[1]) winner = 1 - m_prev;
      else if (req_valid[0])            winner = 0;
      else if (req_valid[1])            winner = 1;
      else                              winner = -1;
      allowed = (m_holder >= 0) ? m_holder : winner;

      for (int x = 0; x < 2; x++) begin
        if (req_valid[x]) begin
          chk((x == 0) ? "ready0" : "ready1", int'(rdy[x]), int'(sf && (x == allowed)));
        end
      end

      if (UartDataInValid && uart_ready) begin
        if (exp_q.size() == 0) begin
          chk("uart_unexpected_byte", 1, 0);
        end else begin
          exp_b = exp_q.pop_front();
          chk("uart_byte", int'(UartDataIn), int'(exp_b));
        end
        out_log.push_back(UartDataIn);
      end

      xfer = -1;
      if (allowed >= 0 && sf) begin
        if (req_valid[allowed]) xfer = allowed;
      end

      if (xfer >= 0) begin
        exp_q.push_back(req_data[xfer]);
        m_data = req_data[xfer];
        m_full = 1'b1;
        if (m_holder < 0) begin
          if (req_last[xfer] || MAXB == 1) begin
            m_prev = xfer;
          end else begin
            m_holder = xfer;
            m_cnt    = 1;
          end
        end else begin
          m_cnt++;
          if (req_last[xfer] || m_cnt == MAXB) begin
            m_prev   = m_holder;
            m_holder = -1;
          end
        end
      end else if (uart_ready) begin
        m_full = 1'b0;
      end
    end
  end

  // Requester driver: holds a byte until accepted, honours per-byte gaps.
  task automatic drive(input int x);
    item_t it;
    bit    have;
    forever begin
      @(posedge Clock);
      #1;
      if (req_valid[x] && acc[x]) begin
        req_valid[x] = 1'b0;
        req_last[x]  = 1'b0;
      end
      if (!req_valid[x]) begin
        have = (x == 0) ? (q0.size() > 0) : (q1.size() > 0);
        if (have) begin
          it = (x == 0) ? q0[0] : q1[0];
          if (it.gap > 0) begin
            it.gap--;
            if (x == 0) q0[0] = it;
            else        q1[0] = it;
          end else begin
            if (x == 0) it = q0.pop_front();
            else        it = q1.pop_front();
            req_data[x]  = it.data;
            req_last[x]  = it.last;
            req_valid[x] = 1'b1;
          end
        end
      end
    end
  endtask

  initial drive(0);
  initial drive(1);

  initial begin
    forever begin
      @(posedge Clock);
      #1;
      case (uart_mode)
        0:       uart_ready = 1'b1;
        1:       uart_ready = ($urandom_range(0, 99) < 70);
        default: uart_ready = 1'b0;
      endcase
    end
  end

  task automatic do_reset();
    @(posedge Clock);
    #1 Reset = 1'b1;
    @(posedge Clock);
    #1 Reset = 1'b0;
    out_log.delete();
    busy_cycles = 0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || req_valid[0] || req_valid[1] || m_full) && n < 5000) begin
      @(negedge Clock);
      n++;
    end
    repeat (2) @(negedge Clock);
    chk({name, "_drain_timeout"}, int'(n >= 5000), 0);
  endtask

  task automatic check_log(input string name);
    chk({name, "_count"}, out_log.size(), want.size());
    for (int i = 0; i < want.size() && i < out_log.size(); i++) begin
      chk({name, "_order"}, int'(out_log[i]), int'(want[i]));
    end
  endtask

  initial begin
    int total;
    int len;
    repeat (3) @(posedge Clock);
    #1 Reset = 1'b0;
    out_log.delete();
    busy_cycles = 0;

    // Single packet
    @(negedge Clock);
    q0.push_back('{8'h41, 1'b0, 0});
    q0.push_back('{8'h42, 1'b1, 0});
    wait_drain("single");
    want = '{8'h41, 8'h42};
    check_log("single");
    chk("single_busy_cycles", busy_cycles, 1);
    chk("single_owner", int'(Owner), 0);
    $display("single packet: %0d bytes out", out_log.size());

    // Tie and lock, then second tie
    do_reset();
    @(negedge Clock);
    q0.push_back('{8'hA0, 1'b0, 0});
    q0.push_back('{8'hA1, 1'b0, 0});
    q0.push_back('{8'hA2, 1'b1, 0});
    q1.push_back('{8'hB0, 1'b0, 0});
    q1.push_back('{8'hB1, 1'b1, 0});
    wait_drain("tie");
    want = '{8'hA0, 8'hA1, 8'hA2, 8'hB0, 8'hB1};
    check_log("tie");
    out_log.delete();
    @(negedge Clock);
    q0.push_back('{8'hE0, 1'b1, 0});
    q1.push_back('{8'hE1, 1'b1, 0});
    wait_drain("tie2");
    want = '{8'hE0, 8'hE1};
    check_log("tie2");
    $display("tie and lock: done");

    // Forced release after MAXB bytes
    do_reset();
    @(negedge Clock);
    for (int i = 0; i < 10; i++) q1.push_back('{8'(8'h10 + i), (i == 9), 0});
    repeat (2) @(negedge Clock);
    q0.push_back('{8'h20, 1'b0, 0});
    q0.push_back('{8'h21, 1'b1, 0});
    wait_drain("forced");
    want = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h21,
             8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h19};
    check_log("forced");
    $display("forced release: %0d bytes out", out_log.size());

    // UART backpressure
    out_log.delete();
    @(negedge Clock);
    for (int i = 0; i < 6; i++) q0.push_back('{8'(8'h30 + i), (i == 5), 0});
    repeat (2) @(negedge Clock);
    uart_mode = 2;
    repeat (6) @(negedge Clock);
    chk("stall_ready0", int'(Req0Ready), 0);
    chk("stall_ready1", int'(Req1Ready), 0);
    uart_mode = 0;
    wait_drain("stall");
    want = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
    check_log("stall");
    $display("backpressure: %0d bytes out", out_log.size());

    // Owner gap mid-packet with the other requester waiting
    do_reset();
    @(negedge Clock);
    q0.push_back('{8'h40, 1'b0, 0});
    q0.push_back('{8'h41, 1'b0, 3});
    q0.push_back('{8'h42, 1'b1, 0});
    q1.push_back('{8'h50, 1'b1, 0});
    wait_drain("gap");
    want = '{8'h40, 8'h41, 8'h42, 8'h50};
    check_log("gap");
    $display("owner gap: %0d bytes out", out_log.size());

    // Reset mid-packet
    @(negedge Clock);
    q0.push_back('{8'h60, 1'b0, 0});
    q0.push_back('{8'h61, 1'b0, 6});
    q0.push_back('{8'h62, 1'b1, 0});
    repeat (3) @(negedge Clock);
    @(posedge Clock);
    #1 Reset = 1'b1;
    @(posedge Clock);
    #1 Reset = 1'b0;
    chk("midrst_valid", int'(UartDataInValid), 0);
    chk("midrst_busy", int'(Busy), 0);
    chk("midrst_owner", int'(Owner), 1);
    wait_drain("midrst");
    $display("reset mid-packet: done");

    // Randomized traffic
    out_log.delete();
    total = 0;
    uart_mode = 1;
    @(negedge Clock);
    for (int p = 0; p < 30; p++) begin
      len = $urandom_range(1, 7);
      for (int b = 0; b < len; b++) begin
        q0.push_back('{8'($urandom), (b == len - 1), (b == 0) ? $urandom_range(0, 5) : $urandom_range(0, 2)});
        total++;
      end
      len = $urandom_range(1, 7);
      for (int b = 0; b < len; b++) begin
        q1.push_back('{8'($urandom), (b == len - 1), (b == 0) ? $urandom_range(0, 5) : $urandom_range(0, 2)});
        total++;
      end
    end
    wait_drain("random");
    chk("random_count", out_log.size(), total);
    $display("random traffic: %0d bytes out", out_log.size());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
